// File: rtl/seed_packet_rx.sv
// seed_packet_rx: deframes 4-byte seed packets (HEADER, x, y, checksum) from the UART byte stream.
// Latency: 1 cycle from the checksum byte strobe to seed_x_in/seed_y_in/seed_valid/seed_locked.
// Backpressure: none; every rx_valid byte is consumed in the cycle it arrives.
//
// Ports:
//   clk_75      in   system clock
//   rst_n       in   synchronous active-low reset
//   rx_data     in   [7:0] received byte, qualified by rx_valid
//   rx_valid    in   one-cycle strobe per received byte
//   seed_x_in   out  [4:0] last accepted peer seed x, held between packets
//   seed_y_in   out  [4:0] last accepted peer seed y, held between packets
//   seed_valid  out  one-cycle pulse when a new seed is latched
//   seed_locked out  level, set once a good packet has been received
//   frame_err   out  one-cycle pulse when a partial packet is discarded
module seed_packet_rx #(
  parameter logic [7:0] HEADER         = 8'hA5,
  parameter int         TIMEOUT_CYCLES = 750000,
  parameter int         CNT_W          = $clog2(TIMEOUT_CYCLES)
) (
  input  logic       clk_75,
  input  logic       rst_n,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic [4:0] seed_x_in,
  output logic [4:0] seed_y_in,
  output logic       seed_valid,
  output logic       seed_locked,
  output logic       frame_err
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GET_X   = 2'd1,
    GET_Y   = 2'd2,
    GET_CHK = 2'd3
  } state_e;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [4:0]       x_tmp_q, x_tmp_d;
  logic [4:0]       y_tmp_q, y_tmp_d;
  logic [4:0]       seed_x_q, seed_x_d;
  logic [4:0]       seed_y_q, seed_y_d;
  logic             valid_q, valid_d;
  logic             locked_q, locked_d;
  logic             err_q, err_d;

  logic             range_ok;
  logic [7:0]       chk_exp;
  logic             bad;

  // Seed bytes only carry 5 significant bits; anything in [7:5] marks a corrupt byte.
  assign range_ok = (rx_data[7:5] == 3'b000);
  assign chk_exp  = {3'b000, x_tmp_q} ^ {3'b000, y_tmp_q} ^ HEADER;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    x_tmp_d  = x_tmp_q;
    y_tmp_d  = y_tmp_q;
    seed_x_d = seed_x_q;
    seed_y_d = seed_y_q;
    locked_d = locked_q;
    valid_d  = 1'b0;
    err_d    = 1'b0;
    bad      = 1'b0;

    unique case (state_q)
      IDLE: begin
        // Non-header bytes in IDLE are line noise between packets, dropped silently.
        if (rx_valid && rx_data == HEADER) state_d = GET_X;
      end
      GET_X: begin
        if (rx_valid) begin
          if (range_ok) begin
            x_tmp_d = rx_data[4:0];
            state_d = GET_Y;
          end else begin
            bad = 1'b1;
          end
        end
      end
      GET_Y: begin
        if (rx_valid) begin
          if (range_ok) begin
            y_tmp_d = rx_data[4:0];
            state_d = GET_CHK;
          end else begin
            bad = 1'b1;
          end
        end
      end
      GET_CHK: begin
        if (rx_valid) begin
          if (rx_data == chk_exp) begin
            seed_x_d = x_tmp_q;
            seed_y_d = y_tmp_q;
            locked_d = 1'b1;
            valid_d  = 1'b1;
            state_d  = IDLE;
          end else begin
            bad = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Inter-byte timeout. A byte on the limit cycle takes priority, so the
    // timeout only fires on a silent cycle. Reaching the limit always leaves
    // for IDLE, so the counter can never advance past CNT_MAX.
    if (state_q == IDLE) begin
      cnt_d = '0;
    end else if (rx_valid) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_MAX) begin
      err_d   = 1'b1;
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    // A rejected byte that happens to be HEADER starts a fresh packet, so a
    // sender restarting mid-packet loses only the truncated one.
    if (bad) begin
      err_d   = 1'b1;
      state_d = (rx_data == HEADER) ? GET_X : IDLE;
    end
  end

  always_ff @(posedge clk_75) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      x_tmp_q  <= '0;
      y_tmp_q  <= '0;
      seed_x_q <= '0;
      seed_y_q <= '0;
      valid_q  <= 1'b0;
      locked_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      x_tmp_q  <= x_tmp_d;
      y_tmp_q  <= y_tmp_d;
      seed_x_q <= seed_x_d;
      seed_y_q <= seed_y_d;
      valid_q  <= valid_d;
      locked_q <= locked_d;
      err_q    <= err_d;
    end
  end

  assign seed_x_in   = seed_x_q;
  assign seed_y_in   = seed_y_q;
  assign seed_valid  = valid_q;
  assign seed_locked = locked_q;
  assign frame_err   = err_q;

endmodule
